// File: rtl/ooo_ifence_sequencer.sv
// FENCE.I sequencer: drains the ROB, flushes the D-cache, invalidates the I-cache,
// then issues a one-cycle fetch redirect to the instruction after the fence.
module ooo_ifence_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifence_ex,
   input  logic [31:0] pc_ex,
   input  logic        rob_empty,
   input  logic        execute_commit_flush,
   input  logic        dflushed,
   input  logic        iflushed,
   output logic        dcache_flush_req,
   output logic        icache_flush_req,
   output logic        ifence_cache_flushing,
   output logic        ifence_flush,
   output logic [31:0] ifence_pc,
   output logic        stall_ex,
   output logic [7:0]  fence_count,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] DRAIN    = 3'd1;
   localparam logic [2:0] DFLUSH   = 3'd2;
   localparam logic [2:0] IFLUSH   = 3'd3;
   localparam logic [2:0] REDIRECT = 3'd4;

   logic [2:0]  state_q, state_d;
   logic        abort_pend_q, abort_pend_d;
   logic [31:0] ifence_pc_q, ifence_pc_d;
   logic [7:0]  fence_count_q, fence_count_d;
   logic        dreq_q, dreq_d;
   logic        ireq_q, ireq_d;
   logic        redirect_q, redirect_d;
   logic        busy_q, busy_d;
   logic        abort_now;
   logic        fence_start;

   // Execute handshake: ifence_ex is held while stall_ex is high; the fence is
   // accepted on the edge where ifence_ex=1, no commit flush, and we are IDLE.
   assign fence_start = (state_q == IDLE) && ifence_ex && !execute_commit_flush;
   // A flush arriving in the same cycle iflushed completes still counts as an abort.
   assign abort_now   = abort_pend_q || execute_commit_flush;

   always_comb begin
      state_d       = state_q;
      abort_pend_d  = abort_pend_q;
      ifence_pc_d   = ifence_pc_q;
      fence_count_d = fence_count_q;
      case (state_q)
         IDLE: begin
            if (fence_start) begin
               ifence_pc_d = pc_ex + 32'd4;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            if (execute_commit_flush) state_d = IDLE;
            else if (rob_empty)       state_d = DFLUSH;
         end
         DFLUSH: begin
            if (execute_commit_flush) abort_pend_d = 1'b1;
            if (dflushed)             state_d      = IFLUSH;
         end
         IFLUSH: begin
            abort_pend_d = abort_now;
            if (iflushed) state_d = abort_now ? IDLE : REDIRECT;
         end
         REDIRECT: begin
            fence_count_d = fence_count_q + 8'd1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) abort_pend_d = 1'b0;
   end

   // Outputs are registered decodes of the next state so they cannot glitch.
   always_comb begin
      dreq_d     = (state_d == DFLUSH);
      ireq_d     = (state_d == IFLUSH);
      redirect_d = (state_d == REDIRECT);
      busy_d     = (state_d == DRAIN) || (state_d == DFLUSH) || (state_d == IFLUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         abort_pend_q  <= 1'b0;
         ifence_pc_q   <= 32'h0000_0000;
         fence_count_q <= 8'h00;
         dreq_q        <= 1'b0;
         ireq_q        <= 1'b0;
         redirect_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         abort_pend_q  <= abort_pend_d;
         ifence_pc_q   <= ifence_pc_d;
         fence_count_q <= fence_count_d;
         dreq_q        <= dreq_d;
         ireq_q        <= ireq_d;
         redirect_q    <= redirect_d;
         busy_q        <= busy_d;
      end
   end

   assign dcache_flush_req      = dreq_q;
   assign icache_flush_req      = ireq_q;
   assign ifence_cache_flushing = dreq_q || ireq_q;
   assign ifence_flush          = redirect_q;
   assign ifence_pc             = ifence_pc_q;
   assign fence_count           = fence_count_q;
   assign state_dbg             = state_q;
   // The IDLE term stalls execute in the acceptance cycle; masked while reset is held.
   assign stall_ex              = busy_q || (fence_start && !rst);

endmodule

// File: tb/tb_ooo_ifence_sequencer.sv
// Directed bench for ooo_ifence_sequencer: a spec-level fence model checked every
// cycle, a redirect-target queue, and literal expectations for the key scenarios.
module tb_ooo_ifence_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifence_ex = 1'b0;
   logic [31:0] pc_ex = 32'h0;
   logic        rob_empty = 1'b0;
   logic        execute_commit_flush = 1'b0;
   logic        dflushed = 1'b0;
   logic        iflushed = 1'b0;
   logic        dcache_flush_req, icache_flush_req, ifence_cache_flushing, ifence_flush, stall_ex;
   logic [31:0] ifence_pc;
   logic [7:0]  fence_count;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   ooo_ifence_sequencer dut (
      .clk(clk), .rst(rst), .ifence_ex(ifence_ex), .pc_ex(pc_ex), .rob_empty(rob_empty),
      .execute_commit_flush(execute_commit_flush), .dflushed(dflushed), .iflushed(iflushed),
      .dcache_flush_req(dcache_flush_req), .icache_flush_req(icache_flush_req),
      .ifence_cache_flushing(ifence_cache_flushing), .ifence_flush(ifence_flush),
      .ifence_pc(ifence_pc), .stall_ex(stall_ex), .fence_count(fence_count), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Fence model: where the current fence is in its life, in spec terms.
   // 0 none, 1 waiting for ROB, 2 D-cache flush, 3 I-cache invalidate, 4 redirect.
   int          m_phase = 0;
   bit          m_abort = 1'b0;
   logic [31:0] m_pc = 32'h0;
   int          m_done = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_abort = 0; m_pc = 32'h0; m_done = 0;
         exp_q.delete();
      end else begin
         case (m_phase)
            0: if (ifence_ex && !execute_commit_flush) begin m_pc = pc_ex + 32'd4; m_phase = 1; end
            1: if (execute_commit_flush) m_phase = 0; else if (rob_empty) m_phase = 2;
            2: begin
               if (execute_commit_flush) m_abort = 1;
               if (dflushed) m_phase = 3;
            end
            3: begin
               if (execute_commit_flush) m_abort = 1;
               if (iflushed) begin
                  m_phase = m_abort ? 0 : 4;
                  if (!m_abort) exp_q.push_back(m_pc);
               end
            end
            default: begin m_done++; m_phase = 0; end
         endcase
         if (m_phase == 0) m_abort = 0;
      end
   end

   int dut_pulses = 0;
   int dreq_cyc = 0;
   int ireq_cyc = 0;

   always @(negedge clk) begin
      chk("dreq", dcache_flush_req, m_phase == 2);
      chk("ireq", icache_flush_req, m_phase == 3);
      chk("flushing", ifence_cache_flushing, m_phase == 2 || m_phase == 3);
      chk("pulse", ifence_flush, m_phase == 4);
      chk("stall", stall_ex, (m_phase >= 1 && m_phase <= 3) ||
          (m_phase == 0 && ifence_ex && !execute_commit_flush && !rst));
      chk("pc", ifence_pc, m_pc);
      chk("count", fence_count, m_done % 256);
      if (ifence_flush) begin
         dut_pulses++;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL redir_unexpected actual=pulse required=none t=%0t", $time);
         end else chk("redir_pc", ifence_pc, exp_q.pop_front());
      end
      if (dcache_flush_req) dreq_cyc++;
      if (icache_flush_req) ireq_cyc++;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_pulse(input int lim, inout int n);
      while (!ifence_flush && n < lim) begin step(); n++; end
      chk("pulse_timeout", ifence_flush, 1'b1);
   endtask

   task automatic quick_fence(input logic [31:0] pc);
      ifence_ex = 1; pc_ex = pc; rob_empty = 1; dflushed = 1; iflushed = 1; execute_commit_flush = 0;
      step(); ifence_ex = 0;
      repeat (4) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int c0;
      int p0;
      #1 rst = 1;
      step(); step();
      chk("rst_pc", ifence_pc, 32'h0);
      chk("rst_count", fence_count, 8'h00);
      chk("rst_stall", stall_ex, 1'b0);
      @(posedge clk); #1 rst = 0;

      // Basic: minimum latency, all handshakes already high.
      ifence_ex = 1; pc_ex = 32'h0000_1000; rob_empty = 1; dflushed = 1; iflushed = 1;
      step(); ifence_ex = 0; n = 1;
      wait_pulse(20, n);
      chk("basic_latency", n, 4);
      chk("basic_pc", ifence_pc, 32'h0000_1004);
      step();
      chk("basic_count", fence_count, 8'd1);

      // Stalls: ROB busy five cycles, dflushed three cycles after DFLUSH entry.
      ifence_ex = 1; pc_ex = 32'h0000_2000; rob_empty = 0; dflushed = 0; iflushed = 0;
      step(); ifence_ex = 0;
      repeat (5) step();
      rob_empty = 1; dreq_cyc = 0;
      step();
      chk("stall_dreq_on", dcache_flush_req, 1'b1);
      step(); step(); dflushed = 1;
      step(); dflushed = 0;
      chk("stall_dreq_cycles", dreq_cyc, 3);
      chk("stall_ireq_on", icache_flush_req, 1'b1);
      step(); iflushed = 1;
      step(); iflushed = 0;
      chk("stall_redirect", ifence_flush, 1'b1);
      chk("stall_pc", ifence_pc, 32'h0000_2004);
      step();
      chk("stall_count", fence_count, 8'd2);

      // Abort during DRAIN.
      c0 = fence_count; dreq_cyc = 0;
      ifence_ex = 1; pc_ex = 32'h0000_3000; rob_empty = 0;
      step(); ifence_ex = 0; execute_commit_flush = 1;
      step(); execute_commit_flush = 0;
      chk("drain_abort_stall", stall_ex, 1'b0);
      repeat (3) step();
      chk("drain_abort_dreq", dreq_cyc, 0);
      chk("drain_abort_count", fence_count, c0);
      chk("drain_abort_pc", ifence_pc, 32'h0000_3004);

      // Abort during DFLUSH: both flushes still run, no redirect.
      p0 = dut_pulses; ireq_cyc = 0;
      ifence_ex = 1; pc_ex = 32'h0000_4000; rob_empty = 1; dflushed = 0; iflushed = 0;
      step(); ifence_ex = 0;
      step(); execute_commit_flush = 1;
      step(); execute_commit_flush = 0;
      chk("dfl_abort_dreq_held", dcache_flush_req, 1'b1);
      dflushed = 1;
      step(); dflushed = 0;
      chk("dfl_abort_ireq", icache_flush_req, 1'b1);
      iflushed = 1;
      step(); iflushed = 0;
      repeat (3) step();
      chk("dfl_abort_no_pulse", dut_pulses, p0);
      chk("dfl_abort_ireq_cycles", ireq_cyc, 1);
      chk("dfl_abort_count", fence_count, c0);

      // Same-cycle ifence_ex and commit flush in IDLE.
      ifence_ex = 1; execute_commit_flush = 1; pc_ex = 32'h0000_5000;
      #1 chk("same_stall", stall_ex, 1'b0);
      step(); ifence_ex = 0; execute_commit_flush = 0;
      chk("same_pc", ifence_pc, 32'h0000_4004);
      chk("same_idle", stall_ex, 1'b0);

      // PC wrap, then fence_count wrap after 256 completed fences.
      quick_fence(32'hFFFF_FFFC);
      chk("wrap_pc", ifence_pc, 32'h0000_0000);
      chk("wrap_count3", fence_count, 8'd3);
      for (int i = 0; i < 253; i++) quick_fence(32'h0001_0000 + 32'(i) * 32'd4);
      chk("count_wrap", fence_count, 8'h00);

      // Reset while in IFLUSH.
      ifence_ex = 1; pc_ex = 32'h0000_6000; rob_empty = 1; dflushed = 1; iflushed = 0;
      step(); ifence_ex = 0;
      step(); step();
      chk("rst_in_iflush", icache_flush_req, 1'b1);
      #2 rst = 1; ifence_ex = 1;
      #1;
      chk("rst_dreq", dcache_flush_req, 1'b0);
      chk("rst_ireq", icache_flush_req, 1'b0);
      chk("rst_flushing", ifence_cache_flushing, 1'b0);
      chk("rst_pulse", ifence_flush, 1'b0);
      chk("rst_stall_mid", stall_ex, 1'b0);
      chk("rst_pc_mid", ifence_pc, 32'h0);
      chk("rst_count_mid", fence_count, 8'h00);
      iflushed = 1; ifence_ex = 0;
      @(posedge clk); #1 rst = 0;
      p0 = dut_pulses;
      ifence_ex = 1; pc_ex = 32'h0000_7000;
      step(); ifence_ex = 0; n = 1;
      chk("post_rst_accept", stall_ex, 1'b1);
      chk("post_rst_pc", ifence_pc, 32'h0000_7004);
      wait_pulse(20, n);
      chk("post_rst_latency", n, 4);
      step();
      chk("post_rst_single", dut_pulses, p0 + 1);
      chk("post_rst_count", fence_count, 8'd1);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
